// File: rtl/npu_pkg.sv
// Shared NPU definitions: MAC array FSM states, default datapath widths and
// output saturation limits.
package npu_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_OUT   = 2'd2
  } mac_state_t;

  localparam int DEF_DW    = 8;
  localparam int DEF_OW    = 16;
  localparam int DEF_ACC_W = 24;

  localparam int DEF_SAT_MAX = (1 << (DEF_OW - 1)) - 1;
  localparam int DEF_SAT_MIN = -(1 << (DEF_OW - 1));

  // Saturation limits for an arbitrary signed output width.
  function automatic longint sat_max(input int ow);
    return (64'sd1 <<< (ow - 1)) - 64'sd1;
  endfunction

  function automatic longint sat_min(input int ow);
    return -(64'sd1 <<< (ow - 1));
  endfunction

endpackage

// File: rtl/mac_lane.sv
// One MAC lane: signed multiply, wrapping accumulate, saturate on capture.
// Optional build macro MAC_ARRAY_RELU_EN clamps negative results to zero.
module mac_lane
  import npu_pkg::*;
#(
  parameter int DW    = DEF_DW,
  parameter int OW    = DEF_OW,
  parameter int ACC_W = DEF_ACC_W
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load,
  input  logic                 acc_en,
  input  logic                 capture,
  input  logic signed [OW-1:0] bias,
  input  logic signed [DW-1:0] a,
  input  logic signed [DW-1:0] b,
  output logic signed [OW-1:0] result
);

  localparam logic signed [ACC_W-1:0] SAT_HI = ACC_W'(sat_max(OW));
  localparam logic signed [ACC_W-1:0] SAT_LO = ACC_W'(sat_min(OW));

  logic signed [2*DW-1:0]  prod;
  logic signed [ACC_W-1:0] prod_ext;
  logic signed [ACC_W-1:0] bias_ext;
  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] acc_next;
  logic signed [OW-1:0]    sat_val;
  logic signed [OW-1:0]    lane_val;

  assign prod     = a * b;
  assign prod_ext = {{(ACC_W - 2*DW){prod[2*DW-1]}}, prod};
  assign bias_ext = ACC_W'($signed(bias));

  // The captured result is taken from the value being written this cycle, so a
  // zero-length job (bias only) and the final beat both land without delay.
  always_comb begin
    acc_next = acc;
    if (load)
      acc_next = bias_ext;
    else if (acc_en)
      acc_next = acc + prod_ext;
  end

  always_comb begin
    sat_val = acc_next[OW-1:0];
    if (acc_next > SAT_HI)
      sat_val = SAT_HI[OW-1:0];
    else if (acc_next < SAT_LO)
      sat_val = SAT_LO[OW-1:0];
  end

`ifdef MAC_ARRAY_RELU_EN
  assign lane_val = sat_val[OW-1] ? '0 : sat_val;
`else
  assign lane_val = sat_val;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc    <= '0;
      result <= '0;
    end else begin
      acc <= acc_next;
      if (capture)
        result <= lane_val;
    end
  end

endmodule

// File: rtl/mac_array.sv
// Multi-lane signed dot-product engine with a job FSM and valid/ready handshakes.
// Build macro MAC_ARRAY_RELU_EN enables ReLU on every lane result.
module mac_array
  import npu_pkg::*;
#(
  parameter int LANES = 4,
  parameter int DW    = DEF_DW,
  parameter int OW    = DEF_OW,
  parameter int ACC_W = DEF_ACC_W,
  parameter int LEN_W = 10
) (
  input  logic                  CLKEXT,
  input  logic                  RST_MAC,
  input  logic                  start,
  input  logic [LEN_W-1:0]      len,
  input  logic [LANES*OW-1:0]   BIAS_IN,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [LANES*DW-1:0]   a,
  input  logic [LANES*DW-1:0]   b,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [LANES*OW-1:0]   result,
  output logic                  busy
);

  mac_state_t       state;
  logic [LEN_W-1:0] cnt;
  logic             take_start;
  logic             xfer;
  logic             final_beat;
  logic             capture;

  // in_ready is registered and high exactly while in ACCUM.
  assign take_start = (state == ST_IDLE) && start;
  assign xfer       = in_ready && in_valid;
  assign final_beat = xfer && (cnt == LEN_W'(1));
  assign capture    = (take_start && (len == '0)) || final_beat;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    mac_lane #(
      .DW   (DW),
      .OW   (OW),
      .ACC_W(ACC_W)
    ) u_lane (
      .clk    (CLKEXT),
      .rst    (RST_MAC),
      .load   (take_start),
      .acc_en (xfer),
      .capture(capture),
      .bias   (BIAS_IN[i*OW +: OW]),
      .a      (a[i*DW +: DW]),
      .b      (b[i*DW +: DW]),
      .result (result[i*OW +: OW])
    );
  end

  always_ff @(posedge CLKEXT or posedge RST_MAC) begin
    if (RST_MAC) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            cnt  <= len;
            busy <= 1'b1;
            if (len == '0) begin
              state     <= ST_OUT;
              out_valid <= 1'b1;
            end else begin
              state    <= ST_ACCUM;
              in_ready <= 1'b1;
            end
          end
        end
        ST_ACCUM: begin
          if (in_valid) begin
            cnt <= cnt - LEN_W'(1);
            if (cnt == LEN_W'(1)) begin
              state     <= ST_OUT;
              in_ready  <= 1'b0;
              out_valid <= 1'b1;
            end
          end
        end
        ST_OUT: begin
          if (out_ready) begin
            state     <= ST_IDLE;
            out_valid <= 1'b0;
            busy      <= 1'b0;
          end
        end
        default: begin
          state     <= ST_IDLE;
          in_ready  <= 1'b0;
          out_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/mac_array.md
MAC_ARRAY -- requirements
Module: mac_array

Interface
REQ-001 Parameter LANES, default 4, number of parallel MAC lanes.
REQ-002 Parameter DW, default 8, signed operand width per lane.
REQ-003 Parameter OW, default 16, signed result/bias width per lane.
REQ-004 Parameter ACC_W, default 24, signed internal accumulator width; SHALL satisfy ACC_W >= 2*DW+1 and ACC_W >= OW.
REQ-005 Parameter LEN_W, default 10, width of beat-count field.
REQ-006 Ports SHALL be as follows; one clock, reset asynchronous active-high:
- CLKEXT  in  1  sole clock, rising edge.
- RST_MAC  in  1  asynchronous active-high reset.
- start  in  1  one-cycle pulse; begins a dot-product job, honoured only in IDLE.
- len  in  LEN_W  number of input beats for the job, sampled with start.
- BIAS_IN  in  LANES*OW  per-lane signed bias, sampled with start.
- in_valid  in  1  a/b beat valid.
- in_ready  out  1  block accepts a/b beat.
- a  in  LANES*DW  per-lane signed activations.
- b  in  LANES*DW  per-lane signed weights.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- result  out  LANES*OW  per-lane signed saturated result.
- busy  out  1  high in any state except IDLE.

Function
REQ-007 FSM states IDLE, ACCUM, OUT; IDLE->ACCUM on start with len>0; IDLE->OUT on start with len==0; ACCUM->OUT on the edge of the len-th accepted beat; OUT->IDLE on out_valid&&out_ready.
REQ-008 On start, each lane accumulator SHALL load BIAS_IN lane sign-extended to ACC_W; beat counter SHALL load len.
REQ-009 in_ready SHALL be 1 only in ACCUM; a beat transfers when in_valid&&in_ready.
REQ-010 Per transfer, each lane SHALL add signed a[i]*b[i] (2*DW-bit product, sign-extended) to its accumulator; counter decrements.
REQ-011 in_valid low in ACCUM SHALL stall without changing accumulators or counter.
REQ-012 On entry to OUT, result lane i SHALL register accumulator i saturated to OW bits (clamp to +2^(OW-1)-1 / -2^(OW-1)); out_valid rises the cycle after the final beat (or after start when len==0).
REQ-013 result and out_valid SHALL hold stable while out_valid&&!out_ready.
REQ-014 start outside IDLE SHALL be ignored; start and final handshake in the same cycle: start ignored.
REQ-015 Accumulator overflow beyond ACC_W SHALL wrap (two's complement); saturation applies only at output.

Reset
REQ-016 RST_MAC high SHALL immediately force IDLE, accumulators/counter 0, result 0, out_valid 0, in_ready 0, busy 0, including mid-job; a job in flight is discarded.

Configuration
REQ-017 Macro MAC_ARRAY_RELU_EN defined: each lane result SHALL be max(saturated value, 0); undefined: saturated signed value passed unchanged; no port differences.

Structure
REQ-018 Shared package npu_pkg SHALL hold FSM state typedef, default DW/OW/ACC_W constants and saturation limit constants.
REQ-019 One sub-module mac_lane (multiply, accumulate, saturate) SHALL be instantiated LANES times via generate; FSM/counter live in mac_array.

Verification
REQ-020 BIAS_IN=10 all lanes, len=2, beats (a=3,b=4),(a=2,b=5) -> every lane result=32, out_valid one cycle after second beat.
REQ-021 out_ready held low 3 cycles in OUT -> result, out_valid stable, in_ready=0; releases to IDLE on handshake.
REQ-022 BIAS_IN=32767, len=1, a=127,b=127 -> result=32767 (saturated); bias -32768, a=-128,b=127 -> -32768.
REQ-023 len=0, BIAS_IN=-5 -> out_valid next cycle, result=-5 (0 with MAC_ARRAY_RELU_EN).
REQ-024 RST_MAC asserted after 1 of 3 beats -> outputs 0 immediately, IDLE; new job afterwards gives correct result.
REQ-025 BIAS_IN=0, len=1, a=-3,b=2, in_valid gap of 2 cycles -> result=-6 without macro, 0 with MAC_ARRAY_RELU_EN.
